// File: rtl/sram_tile_param.sv
// sram_tile_param
//   DATA_BITS x 2^ADDR_BITS synchronous memory tile. It has one fabric write
//   port, one fabric read port and a serial configuration chain. The chain can
//   preload words, set the mode register and read words back. Configuration
//   traffic is arbitrated against fabric traffic.
//
// Ports
//   clk, rst             single clock, asynchronous active-high reset
//   w_en/addr_w/d_fabric_in   fabric write port
//   r_en/addr_r          fabric read request
//   d_fabric_out/rd_valid     read data (holds when rd_valid=0) and strobe
//   conf_out             current mode register
//   shift_enable/shift_in/shift_out   serial frame chain, shift_out = frame[0]
//   config_set           execute the opcode held in the frame
//   cfg_busy/cfg_done    config operation in progress / one-cycle completion
//
// Mode bits
//   conf[0] = extra output register stage on read data
//   conf[1] = write-through on same-address fabric read+write
module sram_tile_param #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 10,
  parameter int CONF_BITS = 2,
  parameter logic [CONF_BITS-1:0] RESET_CONF = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [ADDR_BITS-1:0] addr_w,
  input  logic [DATA_BITS-1:0] d_fabric_in,
  input  logic                 r_en,
  input  logic [ADDR_BITS-1:0] addr_r,
  output logic [DATA_BITS-1:0] d_fabric_out,
  output logic                 rd_valid,
  output logic [CONF_BITS-1:0] conf_out,
  input  logic                 shift_enable,
  input  logic                 shift_in,
  output logic                 shift_out,
  input  logic                 config_set,
  output logic                 cfg_busy,
  output logic                 cfg_done
);

  localparam int FRAME_BITS = 2 + ADDR_BITS + DATA_BITS;
  localparam int DEPTH      = 1 << ADDR_BITS;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SETC  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {IDLE, CWR, CRD, CCAP} state_t;

  state_t                 state, state_nxt;
  logic [FRAME_BITS-1:0]  frame;
  logic [CONF_BITS-1:0]   mode;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic [1:0]             op;
  logic [ADDR_BITS-1:0]   f_addr;
  logic [DATA_BITS-1:0]   f_data;
  logic                   accept;
  logic                   fab_wr, cfg_wr;
  logic                   rd_issue, rd_fast, rd_slow, bypass;
  logic [DATA_BITS-1:0]   rd_word;
  logic [DATA_BITS-1:0]   data_p0, cap_word;
  logic                   vld_p0;

  assign op     = frame[1:0];
  assign f_addr = frame[ADDR_BITS+1:2];
  assign f_data = frame[FRAME_BITS-1:ADDR_BITS+2];

  // The frame is frozen outside IDLE, so op/addr/data stay stable while busy.
  assign accept = (state == IDLE) && config_set && !shift_enable;

  // Config owns the write port in CWR and the read path in CRD.
  assign fab_wr   = w_en && (state != CWR);
  assign cfg_wr   = (state == CWR) && (op == OP_WRITE);
  assign rd_issue = r_en && (state != CRD);
  assign bypass   = mode[1] && fab_wr && (addr_w == addr_r);
  assign rd_word  = bypass ? d_fabric_in : mem[addr_r];
  assign rd_fast  = rd_issue && !mode[0];
  assign rd_slow  = rd_issue && mode[0];

  assign cfg_busy  = (state != IDLE);
  assign shift_out = frame[0];
  assign conf_out  = mode;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op == OP_WRITE || op == OP_SETC) state_nxt = CWR;
          else if (op == OP_READ)              state_nxt = CRD;
        end
      end
      CWR:     state_nxt = IDLE;
      CRD:     state_nxt = CCAP;
      CCAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage: config write wins over a fabric write (the fabric one is dropped in CWR).
  always_ff @(posedge clk) begin
    if (cfg_wr)      mem[f_addr] <= f_data;
    else if (fab_wr) mem[addr_w] <= d_fabric_in;
  end

  // Stage p0: slow-path read data and readback capture word (data only, no reset)
  always_ff @(posedge clk) begin
    if (rd_slow)        data_p0  <= rd_word;
    if (state == CRD)   cap_word <= mem[f_addr];
  end

  // Control state, frame, mode and the output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame        <= '0;
      mode         <= RESET_CONF;
      cfg_done     <= 1'b0;
      vld_p0       <= 1'b0;
      rd_valid     <= 1'b0;
      d_fabric_out <= '0;
    end else begin
      state    <= state_nxt;
      cfg_done <= (accept && op == OP_NOP) || (state == CWR) || (state == CCAP);

      if (shift_enable && state == IDLE)
        frame <= {shift_in, frame[FRAME_BITS-1:1]};
      else if (state == CCAP)
        frame <= {cap_word, f_addr, OP_NOP};

      if (state == CWR && op == OP_SETC)
        mode <= f_data[CONF_BITS-1:0];

      // Latency is fixed at issue. If a slow read and a fast read both target
      // the same output cycle (only possible right after out_reg is cleared),
      // the older in-flight read is delivered and the fast one is lost.
      vld_p0 <= rd_slow;
      if (vld_p0) begin
        rd_valid     <= 1'b1;
        d_fabric_out <= data_p0;
      end else if (rd_fast) begin
        rd_valid     <= 1'b1;
        d_fabric_out <= rd_word;
      end else begin
        rd_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_tile_param.sv
module tb_sram_tile_param;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 2;
  localparam int FW = 2 + AW + DW;
  localparam int NR = 60;

  logic          clk = 1'b0;
  logic          rst, w_en, r_en, shift_enable, shift_in, config_set;
  logic [AW-1:0] addr_w, addr_r;
  logic [DW-1:0] d_fabric_in, d_fabric_out;
  logic          rd_valid, shift_out, cfg_busy, cfg_done;
  logic [CW-1:0] conf_out;

  int checks = 0;
  int errors = 0;

  logic [1:0]    mode_m;
  logic [DW-1:0] mem_m [16];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl [9];

  sram_tile_param #(.DATA_BITS(DW), .ADDR_BITS(AW), .CONF_BITS(CW), .RESET_CONF(2'b00)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .addr_w(addr_w), .d_fabric_in(d_fabric_in),
    .r_en(r_en), .addr_r(addr_r), .d_fabric_out(d_fabric_out), .rd_valid(rd_valid),
    .conf_out(conf_out), .shift_enable(shift_enable), .shift_in(shift_in),
    .shift_out(shift_out), .config_set(config_set), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                       input logic [1:0] op);
    return {d, a, op};
  endfunction

  task automatic shift_frame(input logic [FW-1:0] f);
    for (int i = 0; i < FW; i++) begin
      shift_enable = 1'b1;
      shift_in     = f[i];
      tick();
    end
    shift_enable = 1'b0;
    shift_in     = 1'b0;
  endtask

  task automatic setconf(input logic [1:0] m);
    shift_frame(mk({30'b0, m}, '0, 2'b10));
    config_set = 1'b1;
    tick();
    config_set = 1'b0;
    tick();
    chk("setconf_done", cfg_done, 1);
    chk("setconf_mode", conf_out, m);
    mode_m = m;
  endtask

  task automatic fab_read(input logic [AW-1:0] a);
    r_en = 1'b1; addr_r = a;
    tick();
    r_en = 1'b0;
  endtask

  task automatic rand_phase;
    logic          sv [NR+2];
    logic [DW-1:0] sd [NR+2];
    logic          we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    int            lat;
    lat = mode_m[0] ? 2 : 1;
    for (int i = 0; i < NR + 2; i++) begin sv[i] = 1'b0; sd[i] = '0; end
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = $urandom;
      w_en = 1'b1; addr_w = AW'(16 + i); d_fabric_in = mem_m[i];
      tick();
    end
    w_en = 1'b0;
    for (int c = 0; c < NR + 2; c++) begin
      we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
      if (c < NR) begin
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
        wa = AW'(16 + $urandom_range(0, 15));
        ra = AW'(16 + $urandom_range(0, 15));
        wd = $urandom;
      end
      if (re) begin
        sv[c + lat - 1] = 1'b1;
        sd[c + lat - 1] = (mode_m[1] && we && wa == ra) ? wd : mem_m[ra - 16];
      end
      if (we) mem_m[wa - 16] = wd;
      w_en = we; addr_w = wa; d_fabric_in = wd; r_en = re; addr_r = ra;
      tick();
      chk("rnd_vld", rd_valid, sv[c]);
      if (sv[c]) chk("rnd_data", d_fabric_out, sd[c]);
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] got;
    rst = 1'b1; w_en = 0; r_en = 0; shift_enable = 0; shift_in = 0; config_set = 0;
    addr_w = '0; addr_r = '0; d_fabric_in = '0; mode_m = 2'b00;

    tbl[0] = '{1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 10'd0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 10'd0, 32'h0,        1'b1, 10'd5, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 10'd6, 32'h11112222, 1'b1, 10'd5, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 10'd0, 32'h0,        1'b0, 10'd0, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 10'd0, 32'h0,        1'b1, 10'd6, 1'b1, 32'h11112222};
    tbl[5] = '{1'b1, 10'd6, 32'h33334444, 1'b1, 10'd6, 1'b1, 32'h11112222};
    tbl[6] = '{1'b0, 10'd0, 32'h0,        1'b1, 10'd6, 1'b1, 32'h33334444};
    tbl[7] = '{1'b1, 10'd7, 32'hA5A5A5A5, 1'b0, 10'd0, 1'b0, 32'h33334444};
    tbl[8] = '{1'b0, 10'd0, 32'h0,        1'b1, 10'd7, 1'b1, 32'hA5A5A5A5};

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_dout", d_fabric_out, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_conf", conf_out, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_sout", shift_out, 0);

    // Fabric vectors, mode 00
    for (int i = 0; i < 9; i++) begin
      w_en = tbl[i].we; addr_w = tbl[i].wa; d_fabric_in = tbl[i].wd;
      r_en = tbl[i].re; addr_r = tbl[i].ra;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      chk($sformatf("vec%0d_vld", i), rd_valid, tbl[i].ev);
      chk($sformatf("vec%0d_dout", i), d_fabric_out, tbl[i].ed);
    end

    // Config WRITE through the chain
    shift_frame(mk(32'h12345678, 10'h3FF, 2'b01));
    config_set = 1'b1; tick(); config_set = 1'b0;
    chk("cwr_busy", cfg_busy, 1);
    chk("cwr_done0", cfg_done, 0);
    tick();
    chk("cwr_idle", cfg_busy, 0);
    chk("cwr_done", cfg_done, 1);
    tick();
    chk("cwr_done_pulse", cfg_done, 0);
    fab_read(10'h3FF);
    chk("cwr_rd_vld", rd_valid, 1);
    chk("cwr_rd_data", d_fabric_out, 32'h12345678);

    // Config write wins over fabric write in CWR
    shift_frame(mk(32'h1, 10'd3, 2'b01));
    config_set = 1'b1; tick(); config_set = 1'b0;
    w_en = 1'b1; addr_w = 10'd3; d_fabric_in = 32'hFFFFFFFF;
    tick(); w_en = 1'b0;
    tick();
    fab_read(10'd3);
    chk("coll_wr", d_fabric_out, 32'h1);

    // NOP
    shift_frame(mk(32'h0, 10'd0, 2'b00));
    config_set = 1'b1; tick(); config_set = 1'b0;
    chk("nop_busy", cfg_busy, 0);
    chk("nop_done", cfg_done, 1);

    // config_set together with shift_enable is ignored
    shift_frame(mk(32'h3, 10'd0, 2'b10));
    config_set = 1'b1; shift_enable = 1'b1; tick();
    config_set = 1'b0; shift_enable = 1'b0;
    chk("ign_busy", cfg_busy, 0);
    tick();
    chk("ign_done", cfg_done, 0);
    chk("ign_conf", conf_out, 0);

    // Output register mode
    setconf(2'b01);
    fab_read(10'd5);
    chk("slow_vld_n1", rd_valid, 0);
    tick();
    chk("slow_vld_n2", rd_valid, 1);
    chk("slow_data", d_fabric_out, 32'hDEADBEEF);
    tick();
    chk("slow_vld_n3", rd_valid, 0);

    // Write-through vs. read-old
    setconf(2'b11);
    w_en = 1'b1; addr_w = 10'd6; d_fabric_in = 32'h55556666; r_en = 1'b1; addr_r = 10'd6;
    tick(); w_en = 1'b0; r_en = 1'b0;
    tick();
    chk("wt_new", d_fabric_out, 32'h55556666);
    setconf(2'b01);
    w_en = 1'b1; addr_w = 10'd6; d_fabric_in = 32'h77778888; r_en = 1'b1; addr_r = 10'd6;
    tick(); w_en = 1'b0; r_en = 1'b0;
    tick();
    chk("wt_old", d_fabric_out, 32'h55556666);

    // READBACK of addr 7 with a dropped fabric read in CRD
    shift_frame(mk(32'h0, 10'd7, 2'b11));
    config_set = 1'b1; tick(); config_set = 1'b0;
    chk("rb_crd_busy", cfg_busy, 1);
    r_en = 1'b1; addr_r = 10'd5;
    tick(); r_en = 1'b0;
    chk("rb_ccap_busy", cfg_busy, 1);
    chk("rb_ccap_done", cfg_done, 0);
    chk("rb_ccap_vld", rd_valid, 0);
    tick();
    chk("rb_idle", cfg_busy, 0);
    chk("rb_done", cfg_done, 1);
    chk("rb_drop_vld", rd_valid, 0);
    tick();
    chk("rb_drop_vld2", rd_valid, 0);
    got = '0;
    for (int i = 0; i < FW; i++) begin
      got[i] = shift_out;
      shift_enable = 1'b1; shift_in = 1'b0;
      tick();
    end
    shift_enable = 1'b0;
    chk("rb_frame", got, mk(32'hA5A5A5A5, 10'd7, 2'b00));

    // config_set held while busy is not re-accepted
    shift_frame(mk(32'h0, 10'd7, 2'b11));
    config_set = 1'b1; tick(); tick(); config_set = 1'b0;
    tick();
    chk("busy_hold_done", cfg_done, 1);
    tick();
    chk("busy_hold_idle", cfg_busy, 0);
    chk("busy_hold_done0", cfg_done, 0);

    // Randomized fabric traffic in every mode
    setconf(2'b00); rand_phase();
    setconf(2'b01); rand_phase();
    setconf(2'b11); rand_phase();
    setconf(2'b10); rand_phase();

    // Reset during CRD with a slow read in flight
    setconf(2'b01);
    shift_frame(mk(32'h0, 10'd7, 2'b11));
    config_set = 1'b1; r_en = 1'b1; addr_r = 10'd5;
    tick();
    config_set = 1'b0; r_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_busy", cfg_busy, 0);
    chk("mrst_vld", rd_valid, 0);
    chk("mrst_done", cfg_done, 0);
    chk("mrst_conf", conf_out, 0);
    chk("mrst_dout", d_fabric_out, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld", rd_valid, 0);
      chk("post_rst_busy", cfg_busy, 0);
      chk("post_rst_done", cfg_done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_tile_param.md
# sram_tile_param

Parametrised successor to the fabric SRAM tile: a DATA_BITS × 2^ADDR_BITS synchronous memory with one fabric write port and one fabric read port, plus a serial configuration chain. The chain can preload words, set the tile mode, and read words back. Config traffic is arbitrated against fabric traffic instead of being OR-merged. Optional output register, write-through bypass and a read-valid strobe are selected at runtime through the mode register. The tile sits in the fabric array; its shift chain daisy-chains with neighbouring tiles.

## Interface
Parameters:
- DATA_BITS, 32, word width
- ADDR_BITS, 10, address width; depth = 2^ADDR_BITS
- CONF_BITS, 2, mode register width (≥2)
- RESET_CONF, 0, mode register value after reset
- FRAME_BITS (localparam) = 2 + ADDR_BITS + DATA_BITS

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- w_en  in  1  fabric write enable
- addr_w  in  ADDR_BITS  fabric write address
- d_fabric_in  in  DATA_BITS  fabric write data
- r_en  in  1  fabric read enable
- addr_r  in  ADDR_BITS  fabric read address
- d_fabric_out  out  DATA_BITS  fabric read data
- rd_valid  out  1  d_fabric_out valid this cycle
- conf_out  out  CONF_BITS  current mode register
- shift_enable  in  1  shift config frame one bit
- shift_in  in  1  serial config in
- shift_out  out  1  serial config out = frame[0]
- config_set  in  1  execute frame opcode (level sampled per cycle)
- cfg_busy  out  1  config operation in progress
- cfg_done  out  1  one-cycle pulse on op completion

## Operation
- Frame register F[FRAME_BITS-1:0]: op = F[1:0], addr = F[ADDR_BITS+1:2], data = F[FRAME_BITS-1:ADDR_BITS+2].
- Shift: when shift_enable && state==IDLE, F <= {shift_in, F[FRAME_BITS-1:1]}. After FRAME_BITS shifts, the first bit shifted in sits at F[0].
- config_set is accepted only when state==IDLE and shift_enable==0. Otherwise it is ignored (no queueing).
- Opcodes: 00 NOP (cfg_done only); 01 WRITE mem[addr] <= data; 10 SETCONF mode <= data[CONF_BITS-1:0]; 11 READBACK.
- FSM states: IDLE, CWR, CRD, CCAP.
  - IDLE→CWR on op 01 or 10.
  - IDLE→CRD on op 11.
  - CWR→IDLE, with the write or mode update performed in CWR.
  - CRD→CCAP, with the memory read issued in CRD.
  - CCAP→IDLE, with the data field replaced by the read word, op field set to 00, addr kept.
- cfg_busy = (state != IDLE). cfg_done pulses for one cycle on the transition back to IDLE, and in the cycle after an accepted NOP.
- Arbitration:
  - In CWR a fabric write is dropped, and a fabric read is served normally.
  - In CRD a fabric read is dropped (no rd_valid for it), and a fabric write is performed normally.
  - Config op 01 and a fabric write in the same CWR cycle: config data lands, fabric data is lost.
- Mode bits:
  - conf[0] = out_reg: adds one register stage on read data.
  - conf[1] = write-through: a fabric read and write to the same address in the same cycle returns the new data. With conf[1]=0 it returns the old data.
  - Upper bits have no internal function and appear on conf_out only.
- A mode change takes effect from the cycle after CWR. Reads already in flight complete with the latency that applied at issue.

## Timing
- Reset values: F=0, mode=RESET_CONF, state=IDLE, d_fabric_out=0, rd_valid=0, cfg_busy=0, cfg_done=0, shift_out=0. Memory contents are not reset.
- Read latency with out_reg=0: r_en at cycle N → data and rd_valid at N+1. With out_reg=1: at N+2. Back-to-back reads are pipelined, one per cycle.
- d_fabric_out holds its last value when rd_valid=0.
- Fabric write is committed at the rising edge of the r_en/w_en cycle and is visible to a read issued the next cycle.
- Config op latency from accepted config_set:
  - WRITE/SETCONF: done at +1.
  - READBACK: done at +2, with the frame holding the read word in the cycle cfg_done is high.
- shift_out changes only on clock edges where a shift occurs or the frame is captured.
- rst asserted mid-operation: immediate return to reset values. A partial WRITE at the same edge is not guaranteed. The in-flight read pipeline is flushed, so no rd_valid is produced.

## Test plan
- Reset with RESET_CONF=2'b00: all outputs 0; w_en with addr 5, data 0xDEADBEEF, then r_en addr 5 → 0xDEADBEEF with rd_valid exactly 1 cycle later.
- Shift in a 44-bit frame {data=0x12345678, addr=10'h3FF, op=01}, pulse config_set → cfg_busy for 1 cycle, cfg_done; fabric read of 0x3FF returns 0x12345678.
- SETCONF with data=2'b01, then r_en at N → rd_valid at N+2. Same-address read+write with conf=2'b11 returns new data; with 2'b01 returns old data.
- READBACK of addr 7 holding 0xA5A5A5A5 → cfg_done at +2, then 44 shifts → shift_out emits 00, addr 7, 0xA5A5A5A5 LSB-first.
- Collisions:
  - Fabric write to addr 3 during CWR writing addr 3 = 0x1 → addr 3 reads 0x1.
  - Fabric r_en during CRD → no rd_valid.
  - config_set during busy, or together with shift_enable → ignored.
- Assert rst during CRD with a fabric read in flight → cfg_busy, rd_valid and cfg_done at 0 immediately and stay 0 until new stimulus.
